// File: rtl/vibrato_lfo_mc.sv
// Multi-channel vibrato LFO: one pitch-offset lane per voice, retriggered on
// note start, note change or repeat strike, with optional onset delay.
module vibrato_lfo_mc #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH_W  = 5,
  parameter int unsigned OUT_W    = 9,
  parameter int unsigned RATE_W   = 17,
  parameter int unsigned DELAY_W  = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic [CHANNELS-1:0]          note_on,
  input  logic [CHANNELS-1:0]          note_repeat,
  input  logic [7*CHANNELS-1:0]        note,
  input  logic [1:0]                   wheel,
  input  logic [1:0]                   mode,
  input  logic [DEPTH_W-1:0]           depth,
  input  logic [RATE_W-1:0]            rate,
  input  logic [DELAY_W-1:0]           delay,
  output logic [OUT_W*CHANNELS-1:0]    vib_out,
  output logic [CHANNELS-1:0]          vib_active
);

  localparam int unsigned PW = DEPTH_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_TRI = 2'd0,
    MODE_SQR = 2'd1,
    MODE_SAW = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  state_e               state_q [CHANNELS];
  state_e               state_d [CHANNELS];
  logic [PW-1:0]        pos_q   [CHANNELS];
  logic [PW-1:0]        pos_d   [CHANNELS];
  logic                 dir_q   [CHANNELS];
  logic                 dir_d   [CHANNELS];
  logic [DEPTH_W-1:0]   dl_q    [CHANNELS];
  logic [DEPTH_W-1:0]   dl_d    [CHANNELS];
  logic [RATE_W-1:0]    rcnt_q  [CHANNELS];
  logic [RATE_W-1:0]    rcnt_d  [CHANNELS];
  logic [DELAY_W-1:0]   dcnt_q  [CHANNELS];
  logic [DELAY_W-1:0]   dcnt_d  [CHANNELS];
  logic [PW-1:0]        sq_q    [CHANNELS];
  logic [PW-1:0]        sq_d    [CHANNELS];
  logic [OUT_W-1:0]     out_q   [CHANNELS];
  logic [OUT_W-1:0]     out_d   [CHANNELS];
  logic [CHANNELS-1:0]  act_q;
  logic [CHANNELS-1:0]  act_d;
  logic [CHANNELS-1:0]  pon_q;
  logic [7*CHANNELS-1:0] pnote_q;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  always_comb begin
    logic [PW-1:0] top;
    logic [PW-1:0] p;
    logic [6:0]    nt;
    logic          trig;
    logic          tick;

    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    dl_d    = dl_q;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;
    sq_d    = sq_q;
    out_d   = out_q;
    act_d   = '0;
    top     = '0;
    p       = '0;
    nt      = '0;
    trig    = 1'b0;
    tick    = 1'b0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      nt   = note[7*i +: 7];
      top  = {dl_q[i], 1'b0};
      // Clamp so a mode switch never walks outside 0..2dl.
      p    = (pos_q[i] > top) ? top : pos_q[i];
      trig = note_on[i] & (~pon_q[i] | (nt != pnote_q[7*i +: 7]) | note_repeat[i]);
      tick = (rcnt_q[i] == rate);

      if (!note_on[i]) begin
        // Gate low outranks every trigger cause, including note_repeat.
        state_d[i] = ST_IDLE;
        pos_d[i]   = PW'(dl_q[i]);
        dir_d[i]   = 1'b0;
      end else if (trig) begin
        dl_d[i]    = depth;
        pos_d[i]   = PW'(depth);
        dir_d[i]   = 1'b0;
        rcnt_d[i]  = '0;
        dcnt_d[i]  = '0;
        sq_d[i]    = '0;
        state_d[i] = ((delay == '0) || (wheel != 2'd0)) ? ST_RUN : ST_DELAY;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
          end
          ST_DELAY: begin
            if (wheel != 2'd0) begin
              state_d[i] = ST_RUN;
            end else if (dcnt_q[i] == (delay - DELAY_W'(1))) begin
              state_d[i] = ST_RUN;
            end else begin
              dcnt_d[i] = dcnt_q[i] + DELAY_W'(1);
            end
          end
          ST_RUN: begin
            rcnt_d[i] = tick ? '0 : (rcnt_q[i] + RATE_W'(1));
            if (tick) begin
              case (mode_sel)
                MODE_TRI: begin
                  if (dl_q[i] == '0) begin
                    pos_d[i] = '0;
                  end else if (!dir_q[i]) begin
                    if (p < top) begin
                      pos_d[i] = p + PW'(1);
                    end else begin
                      dir_d[i] = 1'b1;
                      pos_d[i] = p - PW'(1);
                    end
                  end else begin
                    if (p != '0) begin
                      pos_d[i] = p - PW'(1);
                    end else begin
                      dir_d[i] = 1'b0;
                      pos_d[i] = p + PW'(1);
                    end
                  end
                end
                MODE_SQR: begin
                  if (dl_q[i] == '0) begin
                    pos_d[i] = '0;
                    sq_d[i]  = '0;
                  end else if (sq_q[i] == (top - PW'(1))) begin
                    sq_d[i]  = '0;
                    pos_d[i] = (pos_q[i] == top) ? '0 : top;
                  end else begin
                    sq_d[i]  = sq_q[i] + PW'(1);
                  end
                end
                MODE_SAW: begin
                  pos_d[i] = (p < top) ? (p + PW'(1)) : '0;
                end
                default: begin
                end
              endcase
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
        if (mode_sel == MODE_OFF) begin
          pos_d[i] = PW'(dl_q[i]);
        end
      end

      act_d[i] = (state_d[i] == ST_RUN) && (mode_sel != MODE_OFF);
      out_d[i] = OUT_W'(pos_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        pos_q[i]   <= '0;
        dir_q[i]   <= 1'b0;
        dl_q[i]    <= '0;
        rcnt_q[i]  <= '0;
        dcnt_q[i]  <= '0;
        sq_q[i]    <= '0;
        out_q[i]   <= '0;
      end
      act_q   <= '0;
      pon_q   <= '0;
      pnote_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      dl_q    <= dl_d;
      rcnt_q  <= rcnt_d;
      dcnt_q  <= dcnt_d;
      sq_q    <= sq_d;
      out_q   <= out_d;
      act_q   <= act_d;
      pon_q   <= note_on;
      pnote_q <= note;
    end
  end

  always_comb begin
    vib_out = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      vib_out[OUT_W*i +: OUT_W] = out_q[i];
    end
  end

  assign vib_active = act_q;

endmodule

// File: tb/tb_vibrato_lfo_mc.sv
module tb_vibrato_lfo_mc;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [3:0]  note_on;
  logic [3:0]  note_repeat;
  logic [27:0] note;
  logic [1:0]  wheel;
  logic [1:0]  mode;
  logic [4:0]  depth;
  logic [16:0] rate;
  logic [23:0] delay;
  logic [35:0] vib_out;
  logic [3:0]  vib_active;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned tri_exp [24] = '{3,3,4,4,5,5,6,6,5,5,4,4,3,3,2,2,1,1,0,0,1,1,2,2};
  int unsigned sqr_exp [13] = '{2,2,2,2,4,4,4,4,0,0,0,0,4};

  vibrato_lfo_mc #(
    .CHANNELS(4),
    .DEPTH_W (5),
    .OUT_W   (9),
    .RATE_W  (17),
    .DELAY_W (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .note_on    (note_on),
    .note_repeat(note_repeat),
    .note       (note),
    .wheel      (wheel),
    .mode       (mode),
    .depth      (depth),
    .rate       (rate),
    .delay      (delay),
    .vib_out    (vib_out),
    .vib_active (vib_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] lane(input int unsigned i);
    return vib_out[9*i +: 9];
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    en          = 1'b1;
    note_on     = 4'hF;
    note_repeat = 4'h0;
    note        = {7'd67, 7'd64, 7'd62, 7'd60};
    wheel       = 2'd0;
    mode        = 2'd0;
    depth       = 5'd3;
    rate        = 17'd1;
    delay       = 24'd4;

    // reset held with all gates high
    repeat (3) tick();
    chk("rst_out", vib_out, 36'h0);
    chk("rst_act", {32'h0, vib_active}, 36'h0);

    // triangle on ch0: d=3, rate=1, delay=4
    reset_n = 1'b1;
    note_on = 4'h1;
    tick();
    chk("trig_lane0_lag", lane(0), 0);
    tick();
    chk("trig_lane0_centre", lane(0), 3);
    chk("dly_act_e1", vib_active[0], 0);
    tick();
    tick();
    chk("dly_act_e3", vib_active[0], 0);
    tick();
    chk("dly_act_e4", vib_active[0], 1);
    for (int k = 0; k < 24; k++) begin
      tick();
      chk($sformatf("tri_%0d", k), lane(0), tri_exp[k]);
    end

    // retrigger on ch1: d=5, delay=2
    depth   = 5'd5;
    delay   = 24'd2;
    note_on = 4'h3;
    tick();                                   // F0
    tick();                                   // F1
    tick();                                   // F2
    chk("rt_act_run", vib_active[1], 1);
    repeat (4) tick();                        // F3..F6
    chk("rt_lane1_pre", lane(1), 6);
    note_repeat = 4'h2;
    tick();                                   // F7
    note_repeat = 4'h0;
    chk("rt_act_restart", vib_active[1], 0);
    chk("rt_lane1_lag", lane(1), 7);
    tick();                                   // F8
    chk("rt_lane1_centre", lane(1), 5);
    chk("rt_act_f8", vib_active[1], 0);
    tick();                                   // F9
    chk("rt_act_f9", vib_active[1], 1);
    note_repeat = 4'h2;
    note_on     = 4'h1;
    tick();                                   // F10
    note_repeat = 4'h0;
    tick();
    tick();                                   // F12
    chk("off_beats_repeat_act", {32'h0, vib_active}, 36'h1);
    chk("off_lane1_centre", lane(1), 5);

    // wheel bypass + square on ch2: d=2, rate=0
    note_on = 4'h5;
    wheel   = 2'd2;
    mode    = 2'd1;
    depth   = 5'd2;
    rate    = 17'd0;
    delay   = 24'd1000;
    tick();                                   // G0
    chk("whl_act", vib_active[2], 1);
    chk("whl_lane2_lag", lane(2), 0);
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("sqr_%0d", k), lane(2), sqr_exp[k]);
    end

    // saw on ch3 with enable freeze: d=4, rate=0, delay=0
    wheel   = 2'd0;
    mode    = 2'd2;
    depth   = 5'd4;
    delay   = 24'd0;
    note_on = 4'h8;
    tick();                                   // H0
    chk("saw_act", {32'h0, vib_active}, 36'h8);
    tick();
    tick();
    tick();                                   // H3
    chk("saw_lane3_h3", lane(3), 6);
    en      = 1'b0;
    note_on = 4'hA;
    tick();
    chk("frz_lane3_first", lane(3), 6);
    repeat (9) tick();
    chk("frz_lane3_last", lane(3), 6);
    chk("frz_act", {32'h0, vib_active}, 36'h8);
    en = 1'b1;
    tick();                                   // H4
    chk("rsm_lane3_h4", lane(3), 7);
    chk("rsm_act_ch1_trig", {32'h0, vib_active}, 36'hA);
    tick();
    chk("rsm_lane3_h5", lane(3), 8);
    tick();
    chk("rsm_lane3_wrap", lane(3), 0);
    tick();
    chk("rsm_lane3_h7", lane(3), 1);

    // independence: staggered triangle triggers, then mode off
    note_on = 4'h0;
    tick();                                   // I0
    mode    = 2'd0;
    rate    = 17'd0;
    delay   = 24'd0;
    depth   = 5'd1;
    note_on = 4'h1;
    tick();                                   // J0
    depth   = 5'd2;
    note_on = 4'h3;
    tick();                                   // J1
    depth   = 5'd3;
    note_on = 4'h7;
    tick();                                   // J2
    depth   = 5'd0;
    note_on = 4'hF;
    tick();                                   // J3
    tick();                                   // J4
    tick();                                   // J5
    chk("ind_j5", vib_out, {9'd0, 9'd5, 9'd3, 9'd1});
    tick();                                   // J6
    chk("ind_j6", vib_out, {9'd0, 9'd6, 9'd2, 9'd2});
    chk("ind_act", {32'h0, vib_active}, 36'hF);
    depth = 5'd5;
    note  = {7'd67, 7'd64, 7'd62, 7'd61};
    tick();                                   // J7
    tick();                                   // J8
    chk("note_chg_lane0", lane(0), 5);
    mode = 2'd3;
    tick();                                   // J9
    chk("off_act", {32'h0, vib_active}, 36'h0);
    tick();                                   // J10
    chk("off_lanes", vib_out, {9'd0, 9'd3, 9'd2, 9'd5});

    // mid-run reset
    mode    = 2'd0;
    reset_n = 1'b0;
    tick();
    chk("rst2_out", vib_out, 36'h0);
    chk("rst2_act", {32'h0, vib_active}, 36'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
